instr_fetch_ctrl: RTL and testbench
===================================

# instr_fetch_ctrl

Instruction-fetch controller for the 16-bit processor. It owns the fetch PC, drives the 6-bit address into the instruction memory, and captures the returned 16-bit word into a 2-entry prefetch buffer. It presents instructions to decode with a valid/ready handshake and services branch/jump redirects from execute. It sits between the instruction memory and the decode stage.

## Interface
- AW, 6, instruction address width (64-word instruction memory)
- DW, 16, instruction width
- RESET_PC, 0, fetch PC loaded on reset
- CLK  input  1  single clock; all state updates on rising edge
- RST  input  1  asynchronous, active-high reset
- PCI  output  AW  fetch address to instruction memory; equals the fetch PC register
- INSTR_IN  input  DW  memory read data; combinational function of PCI, valid in the same cycle
- IR_OUT  output  DW  instruction at buffer head
- PC_OUT  output  AW  address IR_OUT was fetched from
- IR_VALID  output  1  buffer head holds a valid instruction
- IR_READY  input  1  decode accepts; transfer occurs when IR_VALID && IR_READY
- REDIRECT  input  1  one-cycle pulse; flush buffer and restart fetch at REDIRECT_PC
- REDIRECT_PC  input  AW  redirect target
- HALTED  output  1  fetch stopped by halt opcode (only meaningful with FETCH_HALT_EN)

## Operation
- State machine: RUN, FULL, HALT. Reset enters RUN.
- Buffer count is 0..2. enq = (state==RUN) && (count<2 || deq); deq = IR_VALID && IR_READY.
- On enq: push {PCI, INSTR_IN} and set fetch PC <= PCI+1 (mod 2^AW, so 63 wraps to 0).
- RUN -> FULL when count becomes 2 and no deq occurs. FULL -> RUN on any deq. In FULL, PCI holds and no memory word is captured.
- REDIRECT (highest priority, any state): buffer cleared (count=0), fetch PC <= REDIRECT_PC, state <= RUN. A deq in the same cycle still counts as delivered to decode. Any enq in that cycle is discarded.
- Simultaneous enq and deq at count==2: the head pops, the new word pushes, and count stays 2.
- IR_OUT, PC_OUT are the head entry. When IR_VALID=0 they hold their last value and are don't-care to decode.

## Timing
- Reset values: PCI=RESET_PC, IR_OUT=0, PC_OUT=0, IR_VALID=0, HALTED=0, count=0.
- Latency: the word at PCI is captured at the next rising edge. IR_VALID rises one cycle after the first post-reset edge.
- Throughput: one instruction per cycle with IR_READY held high.
- Redirect bubble: the cycle after REDIRECT has IR_VALID=0. The target instruction appears at IR_OUT one cycle later.
- Reset mid-operation: all state returns immediately, asynchronously, to the reset values.

## Configuration
- FETCH_HALT_EN defined:
  - An enqueued word equal to HALT_OPCODE (16'hFFFF) moves the state to HALT after it is pushed.
  - In HALT there are no further enqueues and PCI holds at halt address+1. The buffer still drains to decode.
  - HALTED=1 in HALT. Only REDIRECT or RST leaves HALT.
- FETCH_HALT_EN undefined:
  - 16'hFFFF is an ordinary instruction.
  - The HALT state and its logic are not compiled.
  - HALTED is tied to 0.

## Structure
- Package fetch_pkg holds:
  - AW/DW defaults, RESET_PC default and HALT_OPCODE
  - the state enum {RUN, FULL, HALT}
  - the buffer entry type {pc[AW-1:0], instr[DW-1:0]}
- Sub-module fetch_fifo: 2-entry FIFO with push/pop/flush, count output and head output. The controller FSM, fetch PC and redirect logic stay in instr_fetch_ctrl.

## Test plan
- Reset test: assert RST mid-run -> PCI=0, IR_VALID=0, HALTED=0 immediately. After deassert, the first edge captures mem[0]. Next cycle IR_VALID=1, IR_OUT=mem[0], PC_OUT=0.
- Streaming: IR_READY=1 for 10 cycles -> PC_OUT sequence 0,1,…,9 with one transfer per cycle and no gaps.
- Backpressure: IR_READY=0 for 4 cycles from reset -> count reaches 2 and PCI holds at 2. Raise IR_READY -> outputs 0,1,2,3 in order with no loss or duplication.
- Redirect: REDIRECT=1, REDIRECT_PC=6'h20 while count=2 and IR_READY=1 -> the head is delivered that cycle, the next cycle has IR_VALID=0, then PC_OUT=0x20 with IR_OUT=mem[0x20].
- Wrap: redirect to 63 -> PC_OUT sequence 63, 0, 1.
- Halt, with FETCH_HALT_EN and mem[4]=16'hFFFF -> words 0..4 are delivered, then HALTED=1, PCI holds 5 and IR_VALID stays 0. A redirect to 0 clears HALTED and resumes fetch. Without the macro, fetch continues to 5, 6, ….

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, opcodes, FSM states and buffer entry type for the fetch stage
package fetch_pkg;
   localparam int AW = 6;
   localparam int DW = 16;
   localparam logic [AW-1:0] RESET_PC_DEF = '0;
   localparam logic [DW-1:0] HALT_OPCODE  = 16'hFFFF;

   typedef enum logic [1:0] {RUN, FULL, HALT} fetch_state_e;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [DW-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - fetch-stage bus: instruction memory port, decode handshake and redirect
interface fetch_if;
   import fetch_pkg::*;

   logic [AW-1:0] PCI;
   logic [DW-1:0] INSTR_IN;
   logic [DW-1:0] IR_OUT;
   logic [AW-1:0] PC_OUT;
   logic          IR_VALID;
   logic          IR_READY;
   logic          REDIRECT;
   logic [AW-1:0] REDIRECT_PC;
   logic          HALTED;

   modport master (
      output PCI, IR_OUT, PC_OUT, IR_VALID, HALTED,
      input  INSTR_IN, IR_READY, REDIRECT, REDIRECT_PC
   );

   modport slave (
      input  PCI, IR_OUT, PC_OUT, IR_VALID, HALTED,
      output INSTR_IN, IR_READY, REDIRECT, REDIRECT_PC
   );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - two-entry shift prefetch buffer; entry 0 is always the head
module fetch_fifo
   import fetch_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t data_i,
   output logic [1:0]   count_o,
   output fetch_entry_t head_o
);
   fetch_entry_t e0_q, e1_q;
   logic [1:0]   count_q;

   // Entries are never cleared on pop or flush so the head holds its last value while empty.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         e0_q    <= '0;
         e1_q    <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         count_q <= '0;
      end else if (push_i && pop_i) begin
         if (count_q == 2'd2) begin
            e0_q <= e1_q;
            e1_q <= data_i;
         end else begin
            e0_q <= data_i;
         end
      end else if (push_i) begin
         if (count_q == 2'd0) e0_q <= data_i;
         else                 e1_q <= data_i;
         count_q <= count_q + 2'd1;
      end else if (pop_i) begin
         if (count_q == 2'd2) e0_q <= e1_q;
         count_q <= count_q - 2'd1;
      end
   end

   assign count_o = count_q;
   assign head_o  = e0_q;
endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - fetch PC, RUN/FULL/HALT FSM and redirect handling around fetch_fifo
// Optional halt-opcode stop is compiled in with FETCH_HALT_EN.
module instr_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [AW-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic     CLK,
   input  logic     RST,
   fetch_if.master  bus
);
   fetch_state_e  state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [1:0]    count;
   fetch_entry_t  head;
   fetch_entry_t  push_data;
   logic          enq, deq;

   assign deq       = bus.IR_VALID && bus.IR_READY;
   assign enq       = (state_q == RUN) && ((count != 2'd2) || deq);
   assign push_data = '{pc: pc_q, instr: bus.INSTR_IN};

   fetch_fifo u_fifo (
      .clk_i   (CLK),
      .rst_i   (RST),
      .push_i  (enq),
      .pop_i   (deq),
      .flush_i (bus.REDIRECT),
      .data_i  (push_data),
      .count_o (count),
      .head_o  (head)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (bus.REDIRECT) begin
         state_d = RUN;
         pc_d    = bus.REDIRECT_PC;
      end else begin
         if (enq) pc_d = pc_q + AW'(1);
`ifdef FETCH_HALT_EN
         if (enq && (bus.INSTR_IN == HALT_OPCODE)) state_d = HALT;
         else
`endif
         // Only a push into one occupied slot without a pop fills the buffer.
         if ((state_q == RUN) && enq && !deq && (count == 2'd1)) state_d = FULL;
         else if ((state_q == FULL) && deq)                        state_d = RUN;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   assign bus.PCI      = pc_q;
   assign bus.IR_OUT   = head.instr;
   assign bus.PC_OUT   = head.pc;
   assign bus.IR_VALID = (count != 2'd0);
`ifdef FETCH_HALT_EN
   assign bus.HALTED   = (state_q == HALT);
`else
   assign bus.HALTED   = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - cycle table plus delivery scoreboard for instr_fetch_ctrl
module tb_instr_fetch_ctrl;
   import fetch_pkg::*;

   typedef struct {
      logic       rdy;
      logic       redir;
      logic [5:0] rpc;
      logic       exp_valid;
      logic [5:0] exp_pc;
      logic [5:0] exp_pci;
   } vec_t;

   typedef struct {
      int pc;
      int instr;
   } sb_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] mem [64];
   int          checks   = 0;
   int          failures = 0;
   bit          sb_on    = 1'b0;
   sb_t         sb_q [$];
   vec_t        vt [18];

   fetch_if bus ();
   assign bus.INSTR_IN = mem[bus.PCI];

   instr_fetch_ctrl dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.master)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t v(input logic rdy, input logic redir, input logic [5:0] rpc,
                              input logic ev, input logic [5:0] epc, input logic [5:0] epci);
      vec_t r;
      r.rdy = rdy; r.redir = redir; r.rpc = rpc;
      r.exp_valid = ev; r.exp_pc = epc; r.exp_pci = epci;
      return r;
   endfunction

   task automatic push_exp(input int pc);
      sb_t e;
      e.pc    = pc;
      e.instr = int'(mem[pc]);
      sb_q.push_back(e);
   endtask

   task automatic reset_dut();
      RST = 1'b1;
      bus.IR_READY = 1'b0;
      bus.REDIRECT = 1'b0;
      bus.REDIRECT_PC = '0;
      @(posedge CLK); #1;
      RST = 1'b0;
   endtask

   always @(negedge CLK) begin
      sb_t e;
      if (sb_on && bus.IR_VALID && bus.IR_READY) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_transfer", int'(bus.PC_OUT), -1);
         end else begin
            e = sb_q.pop_front();
            check("sb_pc_out", int'(bus.PC_OUT), e.pc);
            check("sb_ir_out", int'(bus.IR_OUT), e.instr);
         end
      end
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'h5A00 ^ {2'b00, 6'(i), 2'b00, 6'(i)};

      // cycle-accurate table from reset: backpressure, redirect with full buffer, wrap
      vt[0]  = v(0, 0, 6'h00, 0, 6'h00, 6'h00);
      vt[1]  = v(0, 0, 6'h00, 1, 6'h00, 6'h01);
      vt[2]  = v(0, 0, 6'h00, 1, 6'h00, 6'h02);
      vt[3]  = v(0, 0, 6'h00, 1, 6'h00, 6'h02);
      vt[4]  = v(1, 0, 6'h00, 1, 6'h00, 6'h02);
      vt[5]  = v(1, 0, 6'h00, 1, 6'h01, 6'h02);
      vt[6]  = v(1, 0, 6'h00, 1, 6'h02, 6'h03);
      vt[7]  = v(0, 0, 6'h00, 1, 6'h03, 6'h04);
      vt[8]  = v(1, 1, 6'h20, 1, 6'h03, 6'h05);
      vt[9]  = v(1, 0, 6'h00, 0, 6'h00, 6'h20);
      vt[10] = v(1, 0, 6'h00, 1, 6'h20, 6'h21);
      vt[11] = v(1, 1, 6'h3F, 1, 6'h21, 6'h22);
      vt[12] = v(1, 0, 6'h00, 0, 6'h00, 6'h3F);
      vt[13] = v(1, 0, 6'h00, 1, 6'h3F, 6'h00);
      vt[14] = v(1, 0, 6'h00, 1, 6'h00, 6'h01);
      vt[15] = v(1, 0, 6'h00, 1, 6'h01, 6'h02);
      vt[16] = v(0, 0, 6'h00, 1, 6'h02, 6'h03);
      vt[17] = v(0, 0, 6'h00, 1, 6'h02, 6'h04);

      // asynchronous reset in the middle of streaming
      reset_dut();
      bus.IR_READY = 1'b1;
      repeat (3) begin @(posedge CLK); #1; end
      #1 RST = 1'b1;
      #1;
      check("rst_pci", int'(bus.PCI), 0);
      check("rst_ir_valid", int'(bus.IR_VALID), 0);
      check("rst_halted", int'(bus.HALTED), 0);
      check("rst_ir_out", int'(bus.IR_OUT), 0);
      check("rst_pc_out", int'(bus.PC_OUT), 0);

      reset_dut();
      foreach (vt[i]) if (0) ; // keep table declared above the loop
      push_exp(0); push_exp(1); push_exp(2); push_exp(3);
      push_exp(6'h20); push_exp(6'h21); push_exp(6'h3F); push_exp(0); push_exp(1);
      sb_on = 1'b1;
      for (int i = 0; i < 18; i++) begin
         bus.IR_READY    = vt[i].rdy;
         bus.REDIRECT    = vt[i].redir;
         bus.REDIRECT_PC = vt[i].rpc;
         @(negedge CLK);
         check($sformatf("tbl%0d_valid", i), int'(bus.IR_VALID), int'(vt[i].exp_valid));
         check($sformatf("tbl%0d_pci", i), int'(bus.PCI), int'(vt[i].exp_pci));
         check($sformatf("tbl%0d_halted", i), int'(bus.HALTED), 0);
         if (vt[i].exp_valid) begin
            check($sformatf("tbl%0d_pc_out", i), int'(bus.PC_OUT), int'(vt[i].exp_pc));
            check($sformatf("tbl%0d_ir_out", i), int'(bus.IR_OUT), int'(mem[vt[i].exp_pc]));
         end
         @(posedge CLK); #1;
      end
      bus.IR_READY = 1'b0;
      bus.REDIRECT = 1'b0;
      @(negedge CLK);
      check("table_sb_drained", sb_q.size(), 0);

      // streaming: ten back-to-back transfers
      sb_on = 1'b0;
      reset_dut();
      for (int i = 0; i < 10; i++) push_exp(i);
      sb_on = 1'b1;
      bus.IR_READY = 1'b1;
      repeat (11) begin @(posedge CLK); #1; end
      bus.IR_READY = 1'b0;
      @(negedge CLK);
      check("stream_sb_drained", sb_q.size(), 0);

      // halt opcode at address 4
      sb_on = 1'b0;
      mem[4] = HALT_OPCODE;
      reset_dut();
`ifdef FETCH_HALT_EN
      for (int i = 0; i < 5; i++) push_exp(i);
`else
      for (int i = 0; i < 9; i++) push_exp(i);
`endif
      sb_on = 1'b1;
      bus.IR_READY = 1'b1;
      repeat (10) begin @(posedge CLK); #1; end
      bus.IR_READY = 1'b0;
      @(negedge CLK);
      check("halt_sb_drained", sb_q.size(), 0);
`ifdef FETCH_HALT_EN
      check("halt_halted", int'(bus.HALTED), 1);
      check("halt_pci", int'(bus.PCI), 5);
      check("halt_ir_valid", int'(bus.IR_VALID), 0);
`else
      check("nohalt_halted", int'(bus.HALTED), 0);
      check("nohalt_pci", int'(bus.PCI), 10);
      check("nohalt_ir_valid", int'(bus.IR_VALID), 1);
`endif
      bus.REDIRECT    = 1'b1;
      bus.REDIRECT_PC = 6'h00;
      @(posedge CLK); #1;
      bus.REDIRECT = 1'b0;
      bus.IR_READY = 1'b1;
      push_exp(0); push_exp(1);
      @(negedge CLK);
      check("resume_halted", int'(bus.HALTED), 0);
      check("resume_bubble", int'(bus.IR_VALID), 0);
      repeat (3) begin @(posedge CLK); #1; end
      bus.IR_READY = 1'b0;
      @(negedge CLK);
      check("resume_sb_drained", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
